// File: rtl/eeg_data_rx.sv
// Receive-side deserializer for the ear-EEG ASIC: samples sdata on fdata_G rises, frames words
// on LOAD_G, tags each word with its channel and buffers it in a first-word-fall-through FIFO.
module eeg_data_rx #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CH_W       = 3,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           fdata_G,
  input  logic                           LOAD_G,
  input  logic                           sdata,
  input  logic                           clr_flags,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CH_W+DATA_W-1:0]         m_data,
  output logic                           m_last,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  output logic                           frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned WW = CH_W + DATA_W;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sdata_s1_q, sdata_s2_q;
  logic              fdata_q, load_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic [WW-1:0]     mem_q [FIFO_DEPTH];

  logic              fdata_rise, load_rise;
  logic [DATA_W-1:0] word;
  logic              push, push_ok, pop, full, ovf_set, ferr_set;
  logic [WW-1:0]     head;

  assign fdata_rise = fdata_G & ~fdata_q;
  assign load_rise  = LOAD_G & ~load_q;
  assign word       = {shreg_q[DATA_W-2:0], sdata_s2_q};

  // A LOAD_G rise always takes precedence over a coincident fdata_G rise.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable && load_rise) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
        end
      end
      StShift: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (load_rise) begin
          ferr_set  = 1'b1;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
        end else if (fdata_rise) begin
          shreg_d = word;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            if (ch_cnt_q == CH_W'(NUM_CH - 1)) begin
              state_d = StIdle;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A word arriving at a full FIFO still fits if the head leaves in the same cycle.
  assign pop     = m_valid & m_ready;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  assign overflow_d  = ovf_set | (overflow_q & ~clr_flags);
  assign frame_err_d = ferr_set | (frame_err_q & ~clr_flags);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      shreg_q     <= '0;
      sdata_s1_q  <= 1'b0;
      sdata_s2_q  <= 1'b0;
      fdata_q     <= 1'b0;
      load_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      shreg_q     <= shreg_d;
      sdata_s1_q  <= sdata;
      sdata_s2_q  <= sdata_s1_q;
      fdata_q     <= fdata_G;
      load_q      <= LOAD_G;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ch_cnt_q, word};
  end

  assign head       = mem_q[rd_ptr_q];
  assign m_valid    = (level_q != '0);
  assign m_data     = m_valid ? head : '0;
  assign m_last     = m_valid && (head[WW-1:DATA_W] == CH_W'(NUM_CH - 1));
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_eeg_data_rx.sv
// Bench for eeg_data_rx: directed steps with random payloads, checked every cycle against a
// word-level reference model (expected FIFO contents as a queue, sticky flags as bits).
module tb_eeg_data_rx;

  localparam int DEPTH = 16;
  localparam int NCH   = 8;
  localparam int DW    = 12;

  logic        sys_clk = 1'b0;
  logic        rst_n, enable, fdata_G, LOAD_G, sdata, clr_flags, m_ready;
  logic        m_valid, m_last, overflow, frame_err;
  logic [14:0] m_data;
  logic [4:0]  fifo_level;

  eeg_data_rx dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fdata_G   (fdata_G),
    .LOAD_G    (LOAD_G),
    .sdata     (sdata),
    .clr_flags (clr_flags),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  // Reference model: words expected in the FIFO as ch*4096+data, plus frame progress.
  int unsigned q[$];
  bit          in_frame, pend_push, pend_ferr, ovf_m, ferr_m;
  int          m_bits, m_ch;
  int unsigned m_acc, pend_val;
  logic [11:0] w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit pop_now, ovf_set;
    pop_now = m_ready && (q.size() != 0);
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("frame_err", 32'(frame_err), 32'(ferr_m));
    if (q.size() != 0) begin
      chk("m_data", 32'(m_data), q[0]);
      chk("m_last", 32'(m_last), 32'((q[0] / 4096) == NCH - 1));
    end
    if (pop_now) void'(q.pop_front());
    ovf_set = 1'b0;
    if (pend_push) begin
      if (q.size() < DEPTH) q.push_back(pend_val);
      else ovf_set = 1'b1;
    end
    ovf_m     = ovf_set | (ovf_m & !clr_flags);
    ferr_m    = pend_ferr | (ferr_m & !clr_flags);
    pend_push = 1'b0;
    pend_ferr = 1'b0;
    if (!enable) in_frame = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_load();
    if (!enable) return;
    if (in_frame) pend_ferr = 1'b1;
    in_frame = 1'b1;
    m_bits   = 0;
    m_ch     = 0;
    m_acc    = 0;
  endtask

  task automatic model_bit(input logic b);
    if (!in_frame) return;
    m_acc = (m_acc * 2 + 32'(b)) % 4096;
    m_bits++;
    if (m_bits == DW) begin
      pend_push = 1'b1;
      pend_val  = 32'(m_ch) * 4096 + m_acc;
      m_bits    = 0;
      m_acc     = 0;
      m_ch++;
      if (m_ch == NCH) in_frame = 1'b0;
    end
  endtask

  // sdata changes 3 cycles before the fdata_G rise; rdy pulses m_ready in the edge cycle.
  task automatic send_bit(input logic b, input bit rdy);
    sdata = b;
    tick(); tick(); tick();
    fdata_G = 1'b1;
    model_bit(b);
    if (rdy) m_ready = 1'b1;
    tick();
    fdata_G = 1'b0;
    if (rdy) m_ready = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] wd, input int nbits, input bit rdy_last);
    for (int i = 0; i < nbits; i++) send_bit(wd[11-i], rdy_last && (i == 11));
  endtask

  task automatic load_pulse();
    LOAD_G = 1'b1;
    model_load();
    tick();
    LOAD_G = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    q.delete();
    in_frame  = 1'b0;
    pend_push = 1'b0;
    pend_ferr = 1'b0;
    ovf_m     = 1'b0;
    ferr_m    = 1'b0;
    m_bits    = 0;
    m_ch      = 0;
    m_acc     = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_last"}, 32'(m_last), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; fdata_G = 1'b0; LOAD_G = 1'b0;
    sdata = 1'b0; clr_flags = 1'b0; m_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Nominal frame: words 0..7, consumer always ready.
    enable  = 1'b1;
    m_ready = 1'b1;
    load_pulse();
    for (int c = 0; c < NCH; c++) send_word(12'(c), 12, 1'b0);
    repeat (3) tick();
    chk("nominal_drained", 32'(fifo_level), 0);
    // FSM is back in IDLE: bits without LOAD_G form no word.
    m_ready = 1'b0;
    w = 12'($urandom);
    send_word(w, 12, 1'b0);
    tick();
    chk("idle_ignores_bits", 32'(fifo_level), 0);

    // Latency: word 0xA5C, m_valid exactly one cycle after the 12th edge.
    load_pulse();
    w = 12'hA5C;
    send_word(w, 11, 1'b0);
    sdata = w[0];
    tick(); tick(); tick();
    fdata_G = 1'b1;
    model_bit(w[0]);
    chk("lat_not_yet", 32'(m_valid), 0);
    tick();
    fdata_G = 1'b0;
    chk("lat_valid", 32'(m_valid), 1);
    chk("lat_data", 32'(m_data), 32'h0A5C);

    // Enable drop mid-word: no flag, no partial word, FSM idle.
    w = 12'($urandom);
    send_word(w, 5, 1'b0);
    drop_enable();
    chk("en_drop_ferr", 32'(frame_err), 0);
    chk("en_drop_level", 32'(fifo_level), 1);
    send_word(w, 12, 1'b0);
    tick();
    chk("en_drop_idle", 32'(fifo_level), 1);
    m_ready = 1'b1;
    repeat (2) tick();
    m_ready = 1'b0;

    // Overflow: two frames plus one word with no consumer.
    for (int f = 0; f < 2; f++) begin
      load_pulse();
      for (int c = 0; c < NCH; c++) send_word(12'($urandom), 12, 1'b0);
    end
    chk("full_level", 32'(fifo_level), 16);
    chk("full_no_ovf", 32'(overflow), 0);
    load_pulse();
    send_word(12'($urandom), 12, 1'b0);
    chk("ovf_level", 32'(fifo_level), 16);
    chk("ovf_set", 32'(overflow), 1);
    repeat (4) tick();
    chk("ovf_sticky", 32'(overflow), 1);
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 0);

    // Full FIFO with a pop in the same cycle the next word completes.
    send_word(12'($urandom), 12, 1'b1);
    chk("fullpop_level", 32'(fifo_level), 16);
    chk("fullpop_ovf", 32'(overflow), 0);
    m_ready = 1'b1;
    repeat (20) tick();
    chk("drained", 32'(fifo_level), 0);
    drop_enable();

    // Mid-frame LOAD_G after 5 bits of ch 3.
    load_pulse();
    for (int c = 0; c < 3; c++) send_word(12'($urandom), 12, 1'b0);
    send_word(12'($urandom), 5, 1'b0);
    load_pulse();
    chk("ferr_set", 32'(frame_err), 1);
    m_ready = 1'b0;
    w = 12'($urandom);
    send_word(w, 12, 1'b0);
    chk("restart_tag_ch0", 32'(m_data), 32'(w));
    m_ready = 1'b1;
    repeat (2) tick();
    m_ready = 1'b0;

    // LOAD_G rise coincident with fdata_G rise: that bit is not counted.
    send_word(12'($urandom), 4, 1'b0);
    sdata   = 1'b1;
    LOAD_G  = 1'b1;
    fdata_G = 1'b1;
    model_load();
    tick();
    LOAD_G  = 1'b0;
    fdata_G = 1'b0;
    tick();
    w = 12'($urandom);
    send_word(w, 12, 1'b0);
    chk("coincident_word", 32'(m_data), 32'(w));
    chk("coincident_level", 32'(fifo_level), 1);
    pulse_clr();
    chk("ferr_cleared", 32'(frame_err), 0);
    m_ready = 1'b1;
    repeat (2) tick();
    m_ready = 1'b0;
    drop_enable();

    // Reset asserted mid-frame with words buffered.
    load_pulse();
    for (int c = 0; c < 2; c++) send_word(12'($urandom), 12, 1'b0);
    send_word(12'($urandom), 7, 1'b0);
    chk("pre_reset_level", 32'(fifo_level), 2);
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    model_reset();
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_level", 32'(fifo_level), 0);

    // Recovery: a full random frame after reset.
    m_ready = 1'b1;
    load_pulse();
    for (int c = 0; c < NCH; c++) send_word(12'($urandom), 12, 1'b0);
    repeat (4) tick();
    chk("final_level", 32'(fifo_level), 0);
    chk("final_flags", 32'({overflow, frame_err}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
